// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush/redirect,
// and whole-pipe freeze while data memory is busy, with saturating event counters.
module hazard_ctrl #(
  parameter int ASIZE = 5,
  parameter int ISIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ASIZE-1:0] id_rs1,
  input  logic [ASIZE-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_memRead,
  input  logic             ex_wen,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             mem_branch_taken,
  input  logic [ISIZE-1:0] mem_branch_target,
  input  logic             dmem_busy,
  input  logic             clr_stats,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic             pc_redirect,
  output logic [ISIZE-1:0] pc_target,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
  output logic [15:0]      freeze_cnt
);

  typedef enum logic {RUN, FREEZE} state_t;

  state_t             state_reg, state_next;
  logic               pend_valid_reg, pend_valid_next;
  logic [ISIZE-1:0]   pend_target_reg, pend_target_next;
  logic [15:0]        cnt_reg [3];
  logic [2:0]         inc;

  logic               load_use, br;
  logic [ISIZE-1:0]   br_target;
  logic               hold_c, bubble_c, flush_c, freeze_c, redirect_c;
  logic [ISIZE-1:0]   target_c;

  assign load_use = ex_memRead & ex_wen & (ex_waddr != '0) &
                    ((id_rs1_used & (id_rs1 == ex_waddr)) |
                     (id_rs2_used & (id_rs2 == ex_waddr)));

  // pend_valid can only be set in FREEZE, so this also covers RUN.
  assign br        = pend_valid_reg | mem_branch_taken;
  assign br_target = pend_valid_reg ? pend_target_reg : mem_branch_target;

  always_comb begin
    state_next       = state_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    hold_c           = 1'b0;
    bubble_c         = 1'b0;
    flush_c          = 1'b0;
    freeze_c         = 1'b0;
    redirect_c       = 1'b0;
    target_c         = '0;
    inc              = 3'b000;
    if (dmem_busy) begin
      freeze_c   = 1'b1;
      inc[2]     = 1'b1;
      state_next = FREEZE;
      // The first branch seen while frozen is kept until release.
      if (mem_branch_taken && !pend_valid_reg) begin
        pend_valid_next  = 1'b1;
        pend_target_next = mem_branch_target;
      end
    end else begin
      state_next      = RUN;
      pend_valid_next = 1'b0;
      if (br) begin
        flush_c    = 1'b1;
        redirect_c = 1'b1;
        target_c   = br_target;
        inc[1]     = 1'b1;
      end else if (load_use) begin
        hold_c   = 1'b1;
        bubble_c = 1'b1;
        inc[0]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_reg[gi] <= '0;
        else if (clr_stats)
          cnt_reg[gi] <= '0;
        else if (inc[gi] && (cnt_reg[gi] != 16'hFFFF))
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
      end
    end
  endgenerate

  assign stall_cnt  = cnt_reg[0];
  assign flush_cnt  = cnt_reg[1];
  assign freeze_cnt = cnt_reg[2];

  // Controls are combinational from inputs, so they are gated while in reset.
  assign pc_hold     = hold_c & rst_n;
  assign ifid_hold   = hold_c & rst_n;
  assign idex_bubble = bubble_c & rst_n;
  assign ifid_flush  = flush_c & rst_n;
  assign idex_flush  = flush_c & rst_n;
  assign exmem_flush = flush_c & rst_n;
  assign pipe_freeze = freeze_c & rst_n;
  assign pc_redirect = redirect_c & rst_n;
  assign pc_target   = rst_n ? target_c : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors are queued as
// stimulus is driven and popped when the combinational outputs are sampled.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_waddr;
  logic        id_rs1_used, id_rs2_used, ex_memRead, ex_wen;
  logic        mem_branch_taken, dmem_busy, clr_stats;
  logic [31:0] mem_branch_target;
  logic        pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush, exmem_flush;
  logic        pipe_freeze, pc_redirect;
  logic [31:0] pc_target;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_q [$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_memRead(ex_memRead), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .mem_branch_taken(mem_branch_taken), .mem_branch_target(mem_branch_target),
    .dmem_busy(dmem_busy), .clr_stats(clr_stats),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_freeze(pipe_freeze), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [39:0] ctl(input logic hold, input logic bub, input logic fl,
                                      input logic frz, input logic redir, input logic [31:0] tgt);
    return {hold, hold, bub, fl, fl, fl, frz, redir, tgt};
  endfunction

  function automatic logic [39:0] observed();
    return {pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush, exmem_flush,
            pipe_freeze, pc_redirect, pc_target};
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step(input string tag, input logic [39:0] exp);
    logic [39:0] e;
    exp_q.push_back(exp);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'h0, observed()}, {24'h0, e});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_memRead = 0; ex_wen = 0; ex_waddr = 0;
    mem_branch_taken = 0; mem_branch_target = 0; dmem_busy = 0; clr_stats = 0;
  endtask

  task automatic set_load_use(input logic [4:0] wa);
    ex_memRead = 1; ex_wen = 1; ex_waddr = wa; id_rs1 = 5'd3; id_rs1_used = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    set_load_use(5'd3);
    repeat (2) @(negedge clk);
    step("reset_gates_outputs", ctl(0, 0, 0, 0, 0, 32'h0));
    check("reset_counters", {16'h0, stall_cnt, flush_cnt, freeze_cnt}, 64'h0);
    rst_n = 1'b1;
    idle();
    step("idle", ctl(0, 0, 0, 0, 0, 32'h0));

    // Load-use on rs1: exactly one bubble, then the load has moved on.
    set_load_use(5'd3);
    step("lu_rs1", ctl(1, 1, 0, 0, 0, 32'h0));
    idle();
    step("lu_rs1_clear", ctl(0, 0, 0, 0, 0, 32'h0));
    check("stall_cnt_1", stall_cnt, 1);
    set_load_use(5'd0); id_rs1 = 5'd0;
    step("lu_x0_ignored", ctl(0, 0, 0, 0, 0, 32'h0));
    idle();
    ex_memRead = 1; ex_wen = 1; ex_waddr = 5'd7; id_rs2 = 5'd7;
    step("lu_rs2_unused", ctl(0, 0, 0, 0, 0, 32'h0));
    id_rs2_used = 1;
    step("lu_rs2", ctl(1, 1, 0, 0, 0, 32'h0));
    ex_wen = 0;
    step("lu_no_wen", ctl(0, 0, 0, 0, 0, 32'h0));
    check("stall_cnt_2", stall_cnt, 2);

    // Branch overrides a concurrent load-use.
    idle(); set_load_use(5'd3);
    mem_branch_taken = 1; mem_branch_target = 32'h40;
    step("branch", ctl(0, 0, 1, 0, 1, 32'h40));
    idle();
    step("branch_after", ctl(0, 0, 0, 0, 0, 32'h0));
    check("flush_cnt_1", flush_cnt, 1);
    check("stall_cnt_kept", stall_cnt, 2);

    // Freeze with a branch captured in the first frozen cycle.
    dmem_busy = 1; mem_branch_taken = 1; mem_branch_target = 32'h80;
    step("freeze_1", ctl(0, 0, 0, 1, 0, 32'h0));
    mem_branch_taken = 0; mem_branch_target = 32'h0;
    step("freeze_2", ctl(0, 0, 0, 1, 0, 32'h0));
    mem_branch_taken = 1; mem_branch_target = 32'hC0;
    step("freeze_3_no_overwrite", ctl(0, 0, 0, 1, 0, 32'h0));
    check("freeze_cnt_3", freeze_cnt, 3);
    idle();
    step("freeze_release", ctl(0, 0, 1, 0, 1, 32'h80));
    step("after_release", ctl(0, 0, 0, 0, 0, 32'h0));
    check("flush_cnt_2", flush_cnt, 2);

    // Saturation of stall_cnt, then clear beats the same-cycle increment.
    set_load_use(5'd3);
    repeat (65540) @(negedge clk);
    check("stall_sat", stall_cnt, 16'hFFFF);
    step("lu_at_sat", ctl(1, 1, 0, 0, 0, 32'h0));
    check("stall_sat_hold", stall_cnt, 16'hFFFF);
    clr_stats = 1;
    step("lu_with_clr", ctl(1, 1, 0, 0, 0, 32'h0));
    check("counters_cleared", {16'h0, stall_cnt, flush_cnt, freeze_cnt}, 64'h0);
    idle();

    // Asynchronous reset in FREEZE discards the pending branch.
    dmem_busy = 1; mem_branch_taken = 1; mem_branch_target = 32'h100;
    step("freeze_pend", ctl(0, 0, 0, 1, 0, 32'h0));
    mem_branch_taken = 0;
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", {24'h0, observed()}, 64'h0);
    check("async_rst_freeze_cnt", freeze_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_busy = 0;
    step("after_rst_no_redirect", ctl(0, 0, 0, 0, 0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
